// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: phase constants, FSM states,
// step codes and the Gray-code step classifier.
package quad_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   typedef enum logic {SETTLE, TRACK} state_e;

   typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ERR} step_e;

   // Successor of a phase when turning in the up (A leads B) direction.
   function automatic logic [1:0] next_up(input logic [1:0] ph);
      case (ph)
         PH_00:   next_up = PH_10;
         PH_10:   next_up = PH_11;
         PH_11:   next_up = PH_01;
         default: next_up = PH_00;
      endcase
   endfunction

   function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
      if (cur == prev)
         decode_step = STEP_NONE;
      else if ((cur ^ prev) == 2'b11)
         decode_step = STEP_ERR;
      else if (cur == next_up(prev))
         decode_step = STEP_UP;
      else
         decode_step = STEP_DN;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// One encoder channel: multi-flop synchronizer followed by a stability filter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic filt_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic                   filt_q, filt_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign filt_o = filt_q;

   // Any cycle where the synchronized level agrees with the filter restarts the count.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_s != filt_q) begin
         if (cnt_q + CNT_ONE == CNT_LAST)
            filt_d = sync_s;
         else
            cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: debounced A/B phase, step decode, detent
// accumulator and a settle window that hides the post-reset phase.
module quadrature_decoder
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STEPS_PER_TICK  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enc_a,
   input  logic enc_b,
   output logic tick,
   output logic up_down,
   output logic err
);

   localparam int ACC_W      = $clog2(STEPS_PER_TICK) + 1;
   localparam int SETTLE_LEN = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
   localparam int ST_W       = $clog2(SETTLE_LEN + 1);

   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_TICK - 1);
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(STEPS_PER_TICK - 1));
   localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
   localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_LEN - 1);
   localparam logic [ST_W-1:0] ST_ONE      = ST_W'(1);

   logic                    f_a, f_b;
   logic [1:0]              phase;
   step_e                   step;
   state_e                  state_q, state_d;
   logic [ST_W-1:0]         settle_q, settle_d;
   logic [1:0]              prev_q, prev_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    tick_q, tick_d;
   logic                    err_q, err_d;
   logic                    up_down_q, up_down_d;

   debounce_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk(clk), .reset(reset), .raw_i(enc_a), .filt_o(f_a)
   );

   debounce_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk(clk), .reset(reset), .raw_i(enc_b), .filt_o(f_b)
   );

   assign phase = {f_a, f_b};
   assign step  = decode_step(prev_q, phase);

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      prev_d    = phase;
      acc_d     = acc_q;
      tick_d    = 1'b0;
      err_d     = 1'b0;
      up_down_d = up_down_q;
      if (state_q == SETTLE) begin
         if (settle_q == SETTLE_LAST)
            state_d = TRACK;
         else
            settle_d = settle_q + ST_ONE;
      end else begin
         case (step)
            STEP_UP: begin
               if (acc_q == ACC_MAX) begin
                  tick_d    = 1'b1;
                  up_down_d = 1'b1;
                  acc_d     = '0;
               end else begin
                  acc_d = acc_q + ACC_ONE;
               end
            end
            STEP_DN: begin
               if (acc_q == ACC_MIN) begin
                  tick_d    = 1'b1;
                  up_down_d = 1'b0;
                  acc_d     = '0;
               end else begin
                  acc_d = acc_q - ACC_ONE;
               end
            end
            STEP_ERR: begin
               err_d = 1'b1;
               acc_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SETTLE;
         settle_q  <= '0;
         prev_q    <= PH_00;
         acc_q     <= '0;
         tick_q    <= 1'b0;
         err_q     <= 1'b0;
         up_down_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         prev_q    <= prev_d;
         acc_q     <= acc_d;
         tick_q    <= tick_d;
         err_q     <= err_d;
         up_down_q <= up_down_d;
      end
   end

   assign tick    = tick_q;
   assign err     = err_q;
   assign up_down = up_down_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed and randomized bench for quadrature_decoder against a phase-position
// reference model (ring position arithmetic on the applied encoder states).
module tb_quadrature_decoder;

   localparam int STEPS = 4;
   localparam int LAT   = 7;
   localparam int HOLD  = 20;

   logic clk = 1'b0;
   logic reset;
   logic enc_a, enc_b;
   logic tick, up_down, err;

   int checks = 0;
   int errors = 0;
   int m_pos, m_acc, m_ud;
   int ctr;

   quadrature_decoder #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STEPS_PER_TICK(STEPS)
   ) dut (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .tick(tick), .up_down(up_down), .err(err)
   );

   always #5 clk = ~clk;

   // Position of a phase on the up-rotation ring 00 -> 10 -> 11 -> 01.
   function automatic int pos_of(input logic [1:0] ph);
      case (ph)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] ph_of(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive a new stable phase, hold it, and compare the window against the model.
   task automatic apply(input string tag, input logic [1:0] ph);
      int d, exp_tick, exp_err, nt, ne, t_at, e_at, both, ud_bad;
      logic ud_prev;
      d = (pos_of(ph) - m_pos + 4) % 4;
      exp_tick = 0;
      exp_err  = 0;
      if (d == 1) begin
         if (m_acc == STEPS - 1) begin exp_tick = 1; m_acc = 0; m_ud = 1; end
         else m_acc = m_acc + 1;
      end else if (d == 3) begin
         if (m_acc == -(STEPS - 1)) begin exp_tick = 1; m_acc = 0; m_ud = 0; end
         else m_acc = m_acc - 1;
      end else if (d == 2) begin
         exp_err = 1;
         m_acc   = 0;
      end
      m_pos = pos_of(ph);

      @(negedge clk);
      {enc_a, enc_b} = ph;
      nt = 0; ne = 0; t_at = -1; e_at = -1; both = 0; ud_bad = 0;
      ud_prev = up_down;
      for (int k = 1; k <= HOLD; k++) begin
         @(posedge clk);
         #1;
         if (tick) begin
            nt++;
            t_at = k;
            if (up_down) ctr = (ctr == 99) ? 0 : ctr + 1;
            else         ctr = (ctr == 0) ? 99 : ctr - 1;
         end
         if (err) begin ne++; e_at = k; end
         if (tick && err) both++;
         if (up_down !== ud_prev && !tick) ud_bad++;
         ud_prev = up_down;
      end
      check({tag, " tick_count"}, nt, exp_tick);
      check({tag, " tick_latency"}, t_at, exp_tick ? LAT : -1);
      check({tag, " err_count"}, ne, exp_err);
      check({tag, " err_latency"}, e_at, exp_err ? LAT : -1);
      check({tag, " tick_and_err"}, both, 0);
      check({tag, " up_down_without_tick"}, ud_bad, 0);
      check({tag, " up_down"}, int'(up_down), m_ud);
      check({tag, " acc"}, int'(dut.acc_q), m_acc);
   endtask

   // Short pulse on one channel, then a quiet window where nothing may happen.
   task automatic glitch(input string tag, input int ch, input int w);
      @(negedge clk);
      if (ch == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
      repeat (w) @(negedge clk);
      if (ch == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
      apply(tag, {enc_a, enc_b});
   endtask

   task automatic do_reset(input string tag, input int cycles);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check({tag, " tick"}, int'(tick), 0);
      check({tag, " err"}, int'(err), 0);
      check({tag, " up_down"}, int'(up_down), 1);
      check({tag, " acc"}, int'(dut.acc_q), 0);
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
      m_acc = 0;
      m_ud  = 1;
      m_pos = pos_of({enc_a, enc_b});
   endtask

   initial begin
      reset = 1'b1;
      enc_a = 1'b0;
      enc_b = 1'b0;
      ctr   = 0;
      repeat (2) @(negedge clk);
      check("reset tick", int'(tick), 0);
      check("reset err", int'(err), 0);
      check("reset up_down", int'(up_down), 1);
      check("reset acc", int'(dut.acc_q), 0);
      reset = 1'b0;
      m_pos = 0; m_acc = 0; m_ud = 1;
      apply("settle idle", 2'b00);

      apply("t1 up1", 2'b10);
      apply("t1 up2", 2'b11);
      apply("t1 up3", 2'b01);
      apply("t1 up4", 2'b00);

      ctr = 0;
      apply("t2 dn1", 2'b01);
      apply("t2 dn2", 2'b11);
      apply("t2 dn3", 2'b10);
      apply("t2 dn4", 2'b00);
      check("t2 counter", ctr, 99);

      glitch("t3 bounce", 0, 3);

      apply("t4 jump", 2'b11);

      apply("t5 up1", 2'b01);
      apply("t5 up2", 2'b00);
      apply("t5 up3", 2'b10);
      apply("t5 dn1", 2'b00);
      apply("t5 dn2", 2'b01);
      apply("t5 dn3", 2'b11);
      apply("t5 dn4", 2'b10);
      apply("t5 dn5", 2'b00);
      apply("t5 dn6", 2'b01);
      apply("t5 dn7", 2'b11);

      apply("t6 jump", 2'b00);
      apply("t6 up1", 2'b10);
      apply("t6 up2", 2'b11);
      do_reset("t6 reset", 3);
      apply("t6 settle", 2'b11);
      apply("t6 up3", 2'b01);
      apply("t6 up4", 2'b00);
      apply("t6 up5", 2'b10);
      apply("t6 up6", 2'b11);

      for (int i = 0; i < 60; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4)       apply("rand up", ph_of(m_pos + 1));
         else if (r < 8)  apply("rand dn", ph_of(m_pos + 3));
         else if (r == 8) apply("rand jump", ph_of(m_pos + 2));
         else             glitch("rand bounce", int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Front-end decoder for a two-channel (A/B) incremental rotary encoder. Synchronizes and debounces the raw encoder pins, decodes Gray-code phase transitions, and accumulates sub-steps into detents. Emits a one-cycle `tick` plus a held `up_down` direction, the exact stimulus pair our up/down counter consumes. It sits between the board pins and that counter, and also reports illegal phase jumps.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per channel, ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a channel change, ≥1.
- `STEPS_PER_TICK`, 4: valid phase steps per emitted tick (detent size), ≥1.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `enc_a` in 1: raw encoder channel A, asynchronous to `clk`.
- `enc_b` in 1: raw encoder channel B, asynchronous to `clk`.
- `tick` out 1: one-cycle pulse, one per completed detent.
- `up_down` out 1: direction of the last tick. 1 = up (CW), 0 = down. Held between ticks.
- `err` out 1: one-cycle pulse when an illegal two-bit phase jump is detected.

## Operation
- **Synchronizer:** each channel passes through `SYNC_STAGES` flops. All flops reset to 0.
- **Debounce (per channel):**
  - Filtered value `f` resets to 0. Counter `c` resets to 0.
  - If sync ≠ `f`, then `c` increments. When `c` reaches `DEBOUNCE_CYCLES` on that cycle, `f` takes the sync value and `c` clears.
  - If sync = `f`, then `c` clears. Any bounce shorter than `DEBOUNCE_CYCLES` is discarded.
- **Phase** = {f_a, f_b}. The register `prev` holds the last accepted phase.
- **Step decode** (current vs `prev`):
  - Up sequence: 00→10→11→01→00 (A leads B). Each of these transitions gives +1.
  - Reverse transitions give −1.
  - No change gives no step.
  - Both bits changed gives an illegal jump.
  - `prev` updates to the current phase every cycle.
- **Accumulator:** signed, range −(STEPS_PER_TICK−1) … +(STEPS_PER_TICK−1). Reset value 0.
  - On +1: if acc = STEPS_PER_TICK−1, then tick=1, up_down=1, acc=0. Otherwise acc+1.
  - On −1: if acc = −(STEPS_PER_TICK−1), then tick=1, up_down=0, acc=0. Otherwise acc−1.
  - Direction reversal simply walks acc back; no tick results unless a full detent is completed. This provides inherent hysteresis.
  - Illegal jump: err=1, acc cleared to 0, no tick, `up_down` unchanged.
- **FSM states:**
  - SETTLE (reset state): a settle counter runs for SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles. During it, `prev` tracks the phase, and no steps, ticks, or errors are produced. Then go to TRACK.
  - TRACK: normal decoding as above.
  - There is no other exit; only `reset` returns to SETTLE.
- **Reset values:** tick=0, err=0, up_down=1, acc=0, FSM=SETTLE.

## Timing
- All outputs are registered.
- Latency from a clean edge on `enc_a`/`enc_b` to the corresponding `tick`/`err`: SYNC_STAGES + DEBOUNCE_CYCLES + 1 `clk` edges. With the defaults this is 19.
- `tick` and `err` are high for exactly one cycle. At most one of the two is asserted in any cycle.
- `up_down` changes only in the same cycle that `tick` asserts.
- Minimum accepted channel-change spacing is DEBOUNCE_CYCLES+1 cycles. Faster motion is filtered, and may later surface as `err`.
- Reset mid-operation:
  - All state clears immediately. `tick`/`err` deassert asynchronously.
  - The encoder resting at any phase after reset produces no spurious tick or err, because SETTLE absorbs it.
- Accumulator width: clog2(STEPS_PER_TICK)+1 bits, signed.

## Structure
- **Shared package `quad_pkg`:**
  - Phase encoding constants: PH_00, PH_10, PH_11, PH_01.
  - FSM state typedef {SETTLE, TRACK}.
  - Step encoding: STEP_NONE, STEP_UP, STEP_DN, STEP_ERR.
- **Sub-module `debounce_filter`** (synchronizer + stability counter, parameters SYNC_STAGES and DEBOUNCE_CYCLES). Instantiated once per channel.
- The top level contains the step decode, accumulator, and FSM.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STEPS_PER_TICK=4. Each encoder state is held 20 cycles.

1. Reset, then inputs at 00, then four up steps (10,11,01,00). Expect exactly one tick, with up_down=1, 7 cycles after the fourth edge. No err.
2. From 00, four down steps feed `up_down_counter` (MAX_COUNT=99, starting at 0). Expect one tick with up_down=0, and the counter reads 99.
3. 3-cycle pulse on `enc_a` (bounce). Expect the filtered phase unchanged, no tick, no err.
4. Inputs jump 00→11 in the same cycle. Expect err for 1 cycle, 7 cycles later. acc=0, no tick, up_down unchanged.
5. Three up steps, then three down steps. Expect no tick and acc=0. Four further down steps give exactly one tick with up_down=0.
6. Two up steps (phase 11), assert reset for 3 cycles, then release. Expect no tick or err during SETTLE. Four up steps from 11 then give one tick with up_down=1.
